// File: rtl/ranger_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ranger_pkg
//  Purpose  : Shared types, default parameter values and width helper for the
//             HC-SR04 ranging front-end (hcsr04_ranger, us_tick_gen).
//  Contents : state_e      - ranger FSM state encoding
//             DEF_*        - default timing/range parameters
//             DEGLITCH_LEN - clks a new echo level must persist when the
//                            ECHO_DEGLITCH_EN build option is defined
//             cnt_w()      - bits needed to hold 0..max_val
//  Revision : 1.0 - initial release
// ============================================================================
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_e;

    localparam int unsigned DEF_CLKS_PER_US = 10;
    localparam int unsigned DEF_TRIG_US     = 10;
    localparam int unsigned DEF_US_PER_CM   = 58;
    localparam int unsigned DEF_MAX_CM      = 400;
    localparam int unsigned DEF_WAIT_US     = 5000;
    localparam int unsigned DEF_PERIOD_US   = 60000;
    localparam int unsigned DEF_DIST_W      = 9;

    localparam int unsigned DEGLITCH_LEN    = 4;

    // Width of a counter that must represent every value 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        cnt_w = (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : ranger_pkg
`default_nettype wire

// File: rtl/us_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : us_tick_gen
//  Purpose  : Microsecond prescaler. Counts 0..CLKS_PER_US-1 and raises o_tick
//             for the one cycle in which the count wraps. i_clr restarts the
//             count from 0 on the next cycle (the tick of the current cycle,
//             if any, is still reported).
//  Ports    : clk     - system clock
//             rst_n   - synchronous active-low reset
//             i_clr   - restart prescaler
//             o_tick  - one-cycle strobe every CLKS_PER_US clks
//  Revision : 1.0 - initial release
// ============================================================================
module us_tick_gen
    import ranger_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned CW = cnt_w(CLKS_PER_US - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign o_tick = (cnt_q == CW'(CLKS_PER_US - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (i_clr || o_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : us_tick_gen
`default_nettype wire

// File: rtl/hcsr04_ranger.sv
`default_nettype none
// ============================================================================
//  Module   : hcsr04_ranger
//  Purpose  : HC-SR04 ultrasonic ranging front-end. Issues periodic trigger
//             pulses, times the echo and converts its width to whole cm.
//  Ports    : clk        - system clock
//             rst_n      - synchronous active-low reset
//             ena        - run enable (0 returns to IDLE)
//             echo_in    - raw sensor echo (asynchronous)
//             trig_out   - sensor trigger
//             dist_cm    - last distance in cm, held between strobes
//             dist_valid - one-cycle strobe on each completed measurement
//             timeout    - last result was no echo / out of range
//             busy       - FSM is not IDLE
//  Build    : ECHO_DEGLITCH_EN - when defined, a new synchronised echo level
//             must persist DEGLITCH_LEN clks before it is accepted.
//  Revision : 1.0 - initial release
// ============================================================================
module hcsr04_ranger
    import ranger_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int unsigned TRIG_US     = DEF_TRIG_US,
    parameter int unsigned US_PER_CM   = DEF_US_PER_CM,
    parameter int unsigned MAX_CM      = DEF_MAX_CM,
    parameter int unsigned WAIT_US     = DEF_WAIT_US,
    parameter int unsigned PERIOD_US   = DEF_PERIOD_US,
    parameter int unsigned DIST_W      = DEF_DIST_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              echo_in,
    output logic              trig_out,
    output logic [DIST_W-1:0] dist_cm,
    output logic              dist_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned ST_US_MAX = (TRIG_US > WAIT_US) ? TRIG_US : WAIT_US;
    localparam int unsigned US_W      = cnt_w(ST_US_MAX);
    localparam int unsigned SUB_W     = cnt_w(US_PER_CM - 1);
    localparam int unsigned CM_W      = cnt_w(MAX_CM);
    localparam int unsigned PER_W     = cnt_w(PERIOD_US);

    // ------------------------------------------------------------------
    // Echo synchroniser and edge detect
    // ------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic w_level;
    logic w_rise;
    logic w_fall;

`ifdef ECHO_DEGLITCH_EN
    localparam int unsigned DG_W = cnt_w(DEGLITCH_LEN - 1);

    logic            acc_q;
    logic            acc_d;
    logic [DG_W-1:0] dg_cnt_q;
    logic [DG_W-1:0] dg_cnt_d;

    // A differing level must be seen DEGLITCH_LEN clks in a row to be taken.
    always_comb begin
        acc_d    = acc_q;
        dg_cnt_d = '0;
        if (sync2_q != acc_q) begin
            if (dg_cnt_q == DG_W'(DEGLITCH_LEN - 1)) begin
                acc_d = sync2_q;
            end else begin
                dg_cnt_d = dg_cnt_q + DG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= 1'b0;
            dg_cnt_q <= '0;
        end else begin
            acc_q    <= acc_d;
            dg_cnt_q <= dg_cnt_d;
        end
    end

    assign w_level = acc_q;
`else
    assign w_level = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= echo_in;
            sync2_q <= sync1_q;
            prev_q  <= w_level;
        end
    end

    assign w_rise = w_level & ~prev_q;
    assign w_fall = ~w_level & prev_q;

    // ------------------------------------------------------------------
    // Prescalers: one restarted on every state change, one on TRIG entry
    // ------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    logic   w_st_clr;
    logic   w_st_tick;
    logic   w_per_clr;
    logic   w_per_tick;

    assign w_st_clr  = (state_d != state_q);
    assign w_per_clr = (state_d == TRIG) && (state_q != TRIG);

    us_tick_gen #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_st_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_st_clr),
        .o_tick (w_st_tick)
    );

    us_tick_gen #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_per_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_per_clr),
        .o_tick (w_per_tick)
    );

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    logic [US_W-1:0]   st_us_q,  st_us_d;
    logic [SUB_W-1:0]  sub_q,    sub_d;
    logic [CM_W-1:0]   cm_q,     cm_d;
    logic [PER_W-1:0]  per_us_q, per_us_d;
    logic [DIST_W-1:0] dist_q,   dist_d;
    logic              tout_q,   tout_d;
    logic              valid_q,  valid_d;
    logic              trig_q,   trig_d;
    logic              busy_q,   busy_d;

    logic              w_sub_wrap;
    logic [CM_W-1:0]   w_cm_next;
    logic              w_per_done;

    assign w_sub_wrap = w_st_tick && (sub_q == SUB_W'(US_PER_CM - 1));
    // Includes a cm completed in this very cycle so that a fall coinciding
    // with the final µs tick still credits it.
    assign w_cm_next  = w_sub_wrap ? (cm_q + CM_W'(1)) : cm_q;
    // True from the cycle in which the period counter steps onto PERIOD_US,
    // so the next trigger rises exactly PERIOD_US µs after the previous one.
    assign w_per_done = (per_us_q == PER_W'(PERIOD_US)) ||
                        (w_per_tick && (per_us_q == PER_W'(PERIOD_US - 1)));

    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        cm_d     = cm_q;
        dist_d   = dist_q;
        tout_d   = tout_q;
        valid_d  = 1'b0;
        per_us_d = per_us_q;
        st_us_d  = st_us_q;

        if (w_per_tick && (per_us_q != PER_W'(PERIOD_US))) begin
            per_us_d = per_us_q + PER_W'(1);
        end
        if (w_st_tick && (st_us_q != US_W'(ST_US_MAX))) begin
            st_us_d = st_us_q + US_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (ena) begin
                    state_d = TRIG;
                end
            end
            TRIG: begin
                if (w_st_tick && (st_us_q == US_W'(TRIG_US - 1))) begin
                    state_d = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    state_d = MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                end else if (w_st_tick && (st_us_q == US_W'(WAIT_US - 1))) begin
                    state_d = HOLDOFF;
                    dist_d  = DIST_W'(MAX_CM);
                    tout_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            MEASURE: begin
                if (w_st_tick) begin
                    sub_d = w_sub_wrap ? '0 : (sub_q + SUB_W'(1));
                end
                cm_d = w_cm_next;
                if (w_fall) begin
                    state_d = HOLDOFF;
                    dist_d  = DIST_W'(w_cm_next);
                    tout_d  = 1'b0;
                    valid_d = 1'b1;
                end else if (w_sub_wrap && (cm_q == CM_W'(MAX_CM - 1))) begin
                    state_d = HOLDOFF;
                    dist_d  = DIST_W'(MAX_CM);
                    tout_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            HOLDOFF: begin
                if (w_per_done && !w_level) begin
                    state_d = TRIG;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable overrides everything and discards any pending result.
        if (!ena) begin
            state_d = IDLE;
            dist_d  = dist_q;
            tout_d  = tout_q;
            valid_d = 1'b0;
        end

        if (per_us_d != per_us_q && w_per_clr) begin
            per_us_d = '0;
        end else if (w_per_clr) begin
            per_us_d = '0;
        end
        if (state_d != state_q) begin
            st_us_d = '0;
        end

        trig_d = (state_d == TRIG);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            st_us_q  <= '0;
            sub_q    <= '0;
            cm_q     <= '0;
            per_us_q <= '0;
            dist_q   <= '0;
            tout_q   <= 1'b0;
            valid_q  <= 1'b0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            st_us_q  <= st_us_d;
            sub_q    <= sub_d;
            cm_q     <= cm_d;
            per_us_q <= per_us_d;
            dist_q   <= dist_d;
            tout_q   <= tout_d;
            valid_q  <= valid_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
        end
    end

    assign trig_out   = trig_q;
    assign dist_cm    = dist_q;
    assign dist_valid = valid_q;
    assign timeout    = tout_q;
    assign busy       = busy_q;

endmodule : hcsr04_ranger
`default_nettype wire

// File: tb/tb_hcsr04_ranger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hcsr04_ranger
//  Purpose  : Directed self-checking bench for hcsr04_ranger. Timing values are
//             scaled down (4 clk/µs, 5 µs/cm, 20 cm range, 300 µs wait,
//             1000 µs period) so every scenario fits a short run; expected
//             values below are hand-derived for that scaling.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hcsr04_ranger;

    localparam int unsigned CLKS_PER_US = 4;
    localparam int unsigned TRIG_US     = 10;
    localparam int unsigned US_PER_CM   = 5;
    localparam int unsigned MAX_CM      = 20;
    localparam int unsigned WAIT_US     = 300;
    localparam int unsigned PERIOD_US   = 1000;
    localparam int unsigned DIST_W      = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b0;
    logic              echo_in = 1'b0;
    logic              trig_out;
    logic [DIST_W-1:0] dist_cm;
    logic              dist_valid;
    logic              timeout;
    logic              busy;

    hcsr04_ranger #(
        .CLKS_PER_US (CLKS_PER_US),
        .TRIG_US     (TRIG_US),
        .US_PER_CM   (US_PER_CM),
        .MAX_CM      (MAX_CM),
        .WAIT_US     (WAIT_US),
        .PERIOD_US   (PERIOD_US),
        .DIST_W      (DIST_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .echo_in    (echo_in),
        .trig_out   (trig_out),
        .dist_cm    (dist_cm),
        .dist_valid (dist_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_trig(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (trig_out !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, int'(trig_out === lvl), 1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (dist_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, int'(dist_valid === 1'b1), 1);
    endtask

    // Called just after a trigger fall: echo rises 50 µs later, stays high
    // for width clks, then the result and its one-cycle strobe are checked.
    task automatic echo_pulse(input int width, input int exp_cm, input string tag);
        repeat (200) @(negedge clk);
        echo_in = 1'b1;
        repeat (width) @(negedge clk);
        echo_in = 1'b0;
        wait_valid(50, {tag, "_valid"});
        check_eq({tag, "_dist"}, int'(dist_cm), exp_cm);
        check_eq({tag, "_tout"}, int'(timeout), 0);
        @(negedge clk);
        check_eq({tag, "_strobe_len"}, int'(dist_valid), 0);
        check_eq({tag, "_hold"}, int'(dist_cm), exp_cm);
    endtask

    initial begin
        logic seen;
        int   t1;
        int   w;
        int   tf;
        int   c0;
        int   c1;

        // ---------------- reset ----------------
        rst_n   = 1'b0;
        ena     = 1'b1;
        echo_in = 1'b0;
        seen    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | trig_out;
        end
        check_eq("rst_trig", int'(seen), 0);
        check_eq("rst_dist", int'(dist_cm), 0);
        check_eq("rst_valid", int'(dist_valid), 0);
        check_eq("rst_tout", int'(timeout), 0);
        check_eq("rst_busy", int'(busy), 0);

        rst_n = 1'b1;
        @(negedge clk);
        check_eq("first_trig", int'(trig_out), 1);
        check_eq("first_busy", int'(busy), 1);
        t1 = cyc;

        // ---------------- trigger width: 10 µs = 40 clks ----------------
        w = 0;
        while (trig_out && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("trig_width", w, 40);

        // ---------------- 50 µs echo -> exactly 10 cm ----------------
        echo_pulse(200, 10, "m50us");

        // ---------------- period: 1000 µs = 4000 clks ----------------
        wait_trig(1'b1, 8000, "period_rise");
        check_eq("period_clks", cyc - t1, 4000);
        wait_trig(1'b0, 100, "t2_fall");

        // ---------------- 54 µs echo -> 10 cm (truncated) ----------------
        echo_pulse(216, 10, "m54us");

        // ---------------- 49 µs echo -> 9 cm ----------------
        wait_trig(1'b1, 8000, "t3_rise");
        wait_trig(1'b0, 100, "t3_fall");
        echo_pulse(196, 9, "m49us");

        // ---------------- no echo: 300 µs after trigger fall ----------------
        wait_trig(1'b1, 8000, "t4_rise");
        wait_trig(1'b0, 100, "t4_fall");
        tf = cyc;
        wait_valid(1300, "noecho_valid");
        check_eq("noecho_delay", cyc - tf, 1200);
        check_eq("noecho_dist", int'(dist_cm), 20);
        check_eq("noecho_tout", int'(timeout), 1);

        // ---------------- echo stuck high: saturate at 20 cm ----------------
        wait_trig(1'b1, 8000, "t5_rise");
        wait_trig(1'b0, 100, "t5_fall");
        repeat (200) @(negedge clk);
        echo_in = 1'b1;
        c0 = cyc;
        wait_valid(500, "sat_valid");
        // 3 clks of echo latency + 100 µs * 4 clk/µs
        check_eq("sat_delay", cyc - c0, 403);
        check_eq("sat_dist", int'(dist_cm), 20);
        check_eq("sat_tout", int'(timeout), 1);
        seen = 1'b0;
        while (cyc < c0 + 4800) begin
            @(negedge clk);
            seen = seen | trig_out;
        end
        check_eq("sat_no_trig", int'(seen), 0);
        echo_in = 1'b0;
        c1 = cyc;
        wait_trig(1'b1, 20, "rearm_rise");
        check_eq("rearm_delay", cyc - c1, 3);

        // ---------------- reset in the middle of MEASURE ----------------
        wait_trig(1'b0, 100, "t6_fall");
        repeat (200) @(negedge clk);
        echo_in = 1'b1;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        seen  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | dist_valid;
        end
        check_eq("mrst_valid", int'(seen), 0);
        check_eq("mrst_dist", int'(dist_cm), 0);
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_tout", int'(timeout), 0);
        check_eq("mrst_trig", int'(trig_out), 0);
        echo_in = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);
        check_eq("mrst_retrig", int'(trig_out), 1);
        wait_trig(1'b0, 100, "t7_fall");
        echo_pulse(200, 10, "fresh");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hcsr04_ranger
`default_nettype wire
